// File: rtl/i3c_tgt_mode_sched.sv
// ---------------------------------------------------------------------------
// i3c_tgt_mode_sched
//
// Target-side mode scheduler for the I3C target.
//
// The scheduler moves through IDLE -> SDR -> HDR_ENTER -> HDR -> EXIT -> SDR:
//   - In SDR it enables the ENTHDR detection engine.
//   - Once a broadcast ENTHDR is seen, it spends one cycle in HDR_ENTER and
//     then enables the HDR-DDR engine.
//   - It leaves HDR when it sees the HDR Exit pattern (EXIT_FALL_CNT SDA
//     falls while SCL is low) or when the bus has been idle for too long.
//   - It returns to SDR on the STOP that follows.
// It owns the single SDA-handler interface. Only the engine that matches the
// current state reaches the handler.
//
// Parameters:
//   EXIT_FALL_CNT  SDA falling edges with SCL low that form HDR Exit
//   TMO_W          width of the HDR inactivity timer
//   HDR_TMO        cycles without any SCL edge in HDR before error (nonzero)
//
// Ports:
//   i_sys_clk, i_sys_rst          clock, synchronous active-high reset
//   i_tgt_en                      target enable, low forces IDLE
//   i_scl, i_sda                  synchronized bus lines
//   i_scl_pos_edge/neg_edge       single-cycle SCL edge strobes
//   o_enthdr_en, i_enthdr_*       ENTHDR engine enable, done pulse, SDA ctrl
//   o_ddr_en, i_ddr_*             HDR-DDR engine enable, done pulse, SDA ctrl
//   o_sdahnd_sda/pp_od/en         muxed SDA controls to the SDA handler
//   o_hdr_mode                    bus is in HDR (until the exit STOP)
//   o_frame_cnt                   DDR frames this HDR session, saturating
//   o_mode_err                    sticky HDR timeout flag
// ---------------------------------------------------------------------------
module i3c_tgt_mode_sched #(
  parameter int               EXIT_FALL_CNT = 4,
  parameter int               TMO_W         = 16,
  parameter logic [TMO_W-1:0] HDR_TMO       = 16'hFFFF
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_tgt_en,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_scl_pos_edge,
  input  logic       i_scl_neg_edge,
  output logic       o_enthdr_en,
  input  logic       i_enthdr_done,
  input  logic       i_enthdr_sda,
  input  logic       i_enthdr_pp_od,
  input  logic       i_enthdr_sda_en,
  output logic       o_ddr_en,
  input  logic       i_ddr_done,
  input  logic       i_ddr_sda,
  input  logic       i_ddr_pp_od,
  input  logic       i_ddr_sda_en,
  output logic       o_sdahnd_sda,
  output logic       o_sdahnd_pp_od,
  output logic       o_sdahnd_en,
  output logic       o_hdr_mode,
  output logic [7:0] o_frame_cnt,
  output logic       o_mode_err
);

  localparam int EXIT_W = $clog2(EXIT_FALL_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SDR,
    ST_HDR_ENTER,
    ST_HDR,
    ST_EXIT
  } state_e;

  state_e            state_q, state_d;
  logic              enthdr_en_q, enthdr_en_d;
  logic              ddr_en_q, ddr_en_d;
  logic              hdr_mode_q, hdr_mode_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              mode_err_q, mode_err_d;
  logic [EXIT_W-1:0] exit_cnt_q, exit_cnt_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic              sda_q;

  logic              sda_fall;
  logic              sda_rise;
  logic [EXIT_W-1:0] exit_cnt_nxt;
  logic [TMO_W-1:0]  timer_nxt;
  logic              exit_hit;
  logic              tmo_hit;

  assign sda_fall = sda_q & ~i_sda;
  assign sda_rise = ~sda_q & i_sda;

  // The exit counter only advances on falls while SCL is low. Any SCL rise
  // means real HDR traffic, so a partial exit pattern is discarded.
  always_comb begin
    exit_cnt_nxt = exit_cnt_q;
    if (i_scl_pos_edge) begin
      exit_cnt_nxt = '0;
    end else if (sda_fall && !i_scl) begin
      exit_cnt_nxt = exit_cnt_q + 1'b1;
    end
  end

  assign timer_nxt = (i_scl_pos_edge || i_scl_neg_edge) ? '0 : timer_q + 1'b1;
  assign exit_hit  = (exit_cnt_nxt == EXIT_W'(EXIT_FALL_CNT));
  assign tmo_hit   = (timer_nxt == HDR_TMO);

  // Next-state logic. The state outputs are derived from state_d, so they
  // are valid in the same cycle as the state they describe.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    mode_err_d  = mode_err_q;
    exit_cnt_d  = exit_cnt_q;
    timer_d     = timer_q;

    if (!i_tgt_en) begin
      state_d     = ST_IDLE;
      frame_cnt_d = '0;
      mode_err_d  = 1'b0;
      exit_cnt_d  = '0;
      timer_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SDR;
        end
        ST_SDR: begin
          if (i_enthdr_done) begin
            state_d     = ST_HDR_ENTER;
            frame_cnt_d = '0;
            exit_cnt_d  = '0;
            timer_d     = '0;
          end
        end
        ST_HDR_ENTER: begin
          state_d    = ST_HDR;
          exit_cnt_d = '0;
          timer_d    = '0;
        end
        ST_HDR: begin
          // A frame that completes together with the exit pattern still counts.
          if (i_ddr_done && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
          exit_cnt_d = exit_cnt_nxt;
          timer_d    = timer_nxt;
          if (exit_hit) begin
            state_d    = ST_EXIT;
            exit_cnt_d = '0;
          end else if (tmo_hit) begin
            state_d    = ST_EXIT;
            mode_err_d = 1'b1;
          end
        end
        ST_EXIT: begin
          if (i_scl && sda_rise) begin
            state_d = ST_SDR;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    enthdr_en_d = (state_d == ST_SDR);
    ddr_en_d    = (state_d == ST_HDR);
    hdr_mode_d  = (state_d == ST_HDR_ENTER) || (state_d == ST_HDR) ||
                  (state_d == ST_EXIT);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q     <= ST_IDLE;
      enthdr_en_q <= 1'b0;
      ddr_en_q    <= 1'b0;
      hdr_mode_q  <= 1'b0;
      frame_cnt_q <= '0;
      mode_err_q  <= 1'b0;
      exit_cnt_q  <= '0;
      timer_q     <= '0;
      sda_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      enthdr_en_q <= enthdr_en_d;
      ddr_en_q    <= ddr_en_d;
      hdr_mode_q  <= hdr_mode_d;
      frame_cnt_q <= frame_cnt_d;
      mode_err_q  <= mode_err_d;
      exit_cnt_q  <= exit_cnt_d;
      timer_q     <= timer_d;
      sda_q       <= i_sda;
    end
  end

  // The SDA mux is combinational so engine drive reaches the handler in the
  // same cycle. Outside SDR/HDR the handler is released (idle high, OD).
  always_comb begin
    o_sdahnd_sda   = 1'b1;
    o_sdahnd_pp_od = 1'b0;
    o_sdahnd_en    = 1'b0;
    case (state_q)
      ST_SDR: begin
        o_sdahnd_sda   = i_enthdr_sda;
        o_sdahnd_pp_od = i_enthdr_pp_od;
        o_sdahnd_en    = i_enthdr_sda_en;
      end
      ST_HDR: begin
        o_sdahnd_sda   = i_ddr_sda;
        o_sdahnd_pp_od = i_ddr_pp_od;
        o_sdahnd_en    = i_ddr_sda_en;
      end
      default: begin
        o_sdahnd_sda   = 1'b1;
        o_sdahnd_pp_od = 1'b0;
        o_sdahnd_en    = 1'b0;
      end
    endcase
  end

  assign o_enthdr_en = enthdr_en_q;
  assign o_ddr_en    = ddr_en_q;
  assign o_hdr_mode  = hdr_mode_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_mode_err  = mode_err_q;

endmodule

// File: tb/tb_i3c_tgt_mode_sched.sv
// Testbench for i3c_tgt_mode_sched: directed scenarios followed by random
// bus activity, all compared against a behavioural model of the scheduler.
module tb_i3c_tgt_mode_sched;

   logic       i_sys_clk;
   logic       i_sys_rst;
   logic       i_tgt_en;
   logic       i_scl;
   logic       i_sda;
   logic       i_scl_pos_edge;
   logic       i_scl_neg_edge;
   logic       o_enthdr_en;
   logic       i_enthdr_done;
   logic       i_enthdr_sda;
   logic       i_enthdr_pp_od;
   logic       i_enthdr_sda_en;
   logic       o_ddr_en;
   logic       i_ddr_done;
   logic       i_ddr_sda;
   logic       i_ddr_pp_od;
   logic       i_ddr_sda_en;
   logic       o_sdahnd_sda;
   logic       o_sdahnd_pp_od;
   logic       o_sdahnd_en;
   logic       o_hdr_mode;
   logic [7:0] o_frame_cnt;
   logic       o_mode_err;

   int checks = 0;
   int errors = 0;

   // Behavioural model: bus mode plus simple counters of falls and quiet time
   localparam int M_IDLE  = 0;
   localparam int M_SDR   = 1;
   localparam int M_ENTER = 2;
   localparam int M_HDR   = 3;
   localparam int M_EXIT  = 4;

   int   mMode    = M_IDLE;
   int   mFrames  = 0;
   int   mFalls   = 0;
   int   mQuiet   = 0;
   bit   mErr     = 0;
   bit   mSdaPrev = 1;
   bit   mValid   = 0;
   logic sclPrev  = 0;

   i3c_tgt_mode_sched #(
      .EXIT_FALL_CNT(4),
      .TMO_W(16),
      .HDR_TMO(16'd16)
   ) dut (
      .i_sys_clk(i_sys_clk),
      .i_sys_rst(i_sys_rst),
      .i_tgt_en(i_tgt_en),
      .i_scl(i_scl),
      .i_sda(i_sda),
      .i_scl_pos_edge(i_scl_pos_edge),
      .i_scl_neg_edge(i_scl_neg_edge),
      .o_enthdr_en(o_enthdr_en),
      .i_enthdr_done(i_enthdr_done),
      .i_enthdr_sda(i_enthdr_sda),
      .i_enthdr_pp_od(i_enthdr_pp_od),
      .i_enthdr_sda_en(i_enthdr_sda_en),
      .o_ddr_en(o_ddr_en),
      .i_ddr_done(i_ddr_done),
      .i_ddr_sda(i_ddr_sda),
      .i_ddr_pp_od(i_ddr_pp_od),
      .i_ddr_sda_en(i_ddr_sda_en),
      .o_sdahnd_sda(o_sdahnd_sda),
      .o_sdahnd_pp_od(o_sdahnd_pp_od),
      .o_sdahnd_en(o_sdahnd_en),
      .o_hdr_mode(o_hdr_mode),
      .o_frame_cnt(o_frame_cnt),
      .o_mode_err(o_mode_err)
   );

   // 10-unit clock with rising edges at 5, 15, 25, ...
   initial begin
      i_sys_clk = 1'b0;
      forever #5 i_sys_clk = ~i_sys_clk;
   end

   // Compares one single-bit observation against the model
   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Compares the frame counter against the model
   task automatic checkCount(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advances the model across one clock edge using the currently driven inputs
   task automatic modelStep();
      bit fall;
      bit rise;
      if (i_sys_rst) begin
         mMode = M_IDLE; mFrames = 0; mFalls = 0; mQuiet = 0;
         mErr = 0; mSdaPrev = 1; mValid = 1;
         return;
      end
      fall = mSdaPrev && !i_sda;
      rise = !mSdaPrev && i_sda;
      mSdaPrev = i_sda;
      if (!i_tgt_en) begin
         mMode = M_IDLE; mFrames = 0; mErr = 0;
         return;
      end
      case (mMode)
         M_IDLE: mMode = M_SDR;
         M_SDR: if (i_enthdr_done) begin mMode = M_ENTER; mFrames = 0; end
         M_ENTER: begin mMode = M_HDR; mFalls = 0; mQuiet = 0; end
         M_HDR: begin
            if (i_ddr_done && mFrames < 255) mFrames++;
            if (i_scl_pos_edge) mFalls = 0;
            else if (fall && !i_scl) mFalls++;
            if (i_scl_pos_edge || i_scl_neg_edge) mQuiet = 0;
            else mQuiet++;
            if (mFalls == 4) mMode = M_EXIT;
            else if (mQuiet == 16) begin mErr = 1; mMode = M_EXIT; end
         end
         M_EXIT: if (i_scl && rise) mMode = M_SDR;
         default: mMode = M_IDLE;
      endcase
   endtask

   // One clock cycle: derive SCL strobes, check the SDA mux before the edge,
   // then check the registered outputs after it. Done pulses last one cycle.
   task automatic applyStimulus();
      logic expSda, expPp, expEn;
      i_scl_pos_edge = i_scl & ~sclPrev;
      i_scl_neg_edge = ~i_scl & sclPrev;
      sclPrev = i_scl;
      #1;
      if (mValid) begin
         expSda = 1'b1; expPp = 1'b0; expEn = 1'b0;
         if (mMode == M_SDR) begin
            expSda = i_enthdr_sda; expPp = i_enthdr_pp_od; expEn = i_enthdr_sda_en;
         end else if (mMode == M_HDR) begin
            expSda = i_ddr_sda; expPp = i_ddr_pp_od; expEn = i_ddr_sda_en;
         end
         checkOutput("mux_sda", o_sdahnd_sda, expSda);
         checkOutput("mux_pp_od", o_sdahnd_pp_od, expPp);
         checkOutput("mux_en", o_sdahnd_en, expEn);
      end
      modelStep();
      @(posedge i_sys_clk);
      #2;
      checkOutput("enthdr_en", o_enthdr_en, mMode == M_SDR);
      checkOutput("ddr_en", o_ddr_en, mMode == M_HDR);
      checkOutput("hdr_mode", o_hdr_mode, mMode == M_ENTER || mMode == M_HDR || mMode == M_EXIT);
      checkCount("frame_cnt", o_frame_cnt, 8'(mFrames));
      checkOutput("mode_err", o_mode_err, mErr);
      i_enthdr_done = 1'b0;
      i_ddr_done = 1'b0;
   endtask

   // Produces n SDA falling edges while SCL is held low
   task automatic sdaFallsLow(input int n);
      i_scl = 1'b0;
      for (int k = 0; k < n; k++) begin
         i_sda = 1'b1; applyStimulus();
         i_sda = 1'b0; applyStimulus();
      end
   endtask

   // From SDR: pulse ENTHDR done, pass through HDR_ENTER into HDR
   task automatic enterHdr();
      i_enthdr_done = 1'b1; applyStimulus();
      applyStimulus();
   endtask

   // STOP: SDA low, SCL high, then SDA rises; leaves SCL low afterwards
   task automatic stopCond();
      i_sda = 1'b0; applyStimulus();
      i_scl = 1'b1; applyStimulus();
      i_sda = 1'b1; applyStimulus();
      i_scl = 1'b0; applyStimulus();
   endtask

   initial begin
      i_sys_rst = 1'b1; i_tgt_en = 1'b1;
      i_scl = 1'b0; i_sda = 1'b1;
      i_scl_pos_edge = 1'b0; i_scl_neg_edge = 1'b0;
      i_enthdr_done = 1'b0; i_enthdr_sda = 1'b1; i_enthdr_pp_od = 1'b0; i_enthdr_sda_en = 1'b0;
      i_ddr_done = 1'b0; i_ddr_sda = 1'b1; i_ddr_pp_od = 1'b0; i_ddr_sda_en = 1'b0;

      // Reset state
      applyStimulus();
      applyStimulus();
      checkOutput("rst_sda", o_sdahnd_sda, 1'b1);
      checkOutput("rst_en", o_sdahnd_en, 1'b0);
      checkOutput("rst_pp_od", o_sdahnd_pp_od, 1'b0);
      i_sys_rst = 1'b0;
      applyStimulus();
      checkOutput("sdr_enthdr_en", o_enthdr_en, 1'b1);

      // ENTHDR latency: hdr_mode one cycle after done, ddr_en after two
      i_enthdr_done = 1'b1; applyStimulus();
      checkOutput("enter_hdr_mode", o_hdr_mode, 1'b1);
      checkOutput("enter_ddr_en", o_ddr_en, 1'b0);
      checkOutput("enter_enthdr_en", o_enthdr_en, 1'b0);
      applyStimulus();
      checkOutput("hdr_ddr_en", o_ddr_en, 1'b1);

      // DDR engine reaches the handler, ENTHDR engine does not
      i_ddr_sda = 1'b0; i_ddr_sda_en = 1'b1; i_ddr_pp_od = 1'b1;
      i_enthdr_sda_en = 1'b1; i_enthdr_sda = 1'b1; i_enthdr_pp_od = 1'b0;
      applyStimulus();
      checkOutput("hdr_mux_sda", o_sdahnd_sda, 1'b0);
      checkOutput("hdr_mux_en", o_sdahnd_en, 1'b1);
      checkOutput("hdr_mux_pp_od", o_sdahnd_pp_od, 1'b1);

      // Three frames, then the exit pattern
      for (int k = 0; k < 3; k++) begin
         i_ddr_done = 1'b1; applyStimulus();
      end
      sdaFallsLow(4);
      checkCount("exit_frames", o_frame_cnt, 8'd3);
      checkOutput("exit_ddr_en", o_ddr_en, 1'b0);
      checkOutput("exit_hdr_mode", o_hdr_mode, 1'b1);
      i_scl = 1'b1; applyStimulus();
      i_sda = 1'b1; applyStimulus();
      checkOutput("stop_hdr_mode", o_hdr_mode, 1'b0);
      checkOutput("stop_enthdr_en", o_enthdr_en, 1'b1);
      i_scl = 1'b0; applyStimulus();

      // Exit noise: an SCL rise discards a partial pattern
      enterHdr();
      sdaFallsLow(3);
      i_scl = 1'b1; applyStimulus();
      sdaFallsLow(3);
      checkOutput("noise_still_hdr", o_ddr_en, 1'b1);
      i_sda = 1'b1; applyStimulus();
      i_sda = 1'b0; i_ddr_done = 1'b1; applyStimulus();
      checkOutput("noise_exit", o_ddr_en, 1'b0);
      checkCount("exit_with_frame", o_frame_cnt, 8'd1);
      stopCond();

      // Inactivity timeout: 16 quiet cycles in HDR
      enterHdr();
      for (int k = 0; k < 15; k++) applyStimulus();
      checkOutput("tmo_not_yet", o_ddr_en, 1'b1);
      applyStimulus();
      checkOutput("tmo_err", o_mode_err, 1'b1);
      checkOutput("tmo_exit", o_ddr_en, 1'b0);
      stopCond();
      enterHdr();
      checkOutput("err_sticky", o_mode_err, 1'b1);
      i_tgt_en = 1'b0; applyStimulus();
      checkOutput("dis_err", o_mode_err, 1'b0);
      checkOutput("dis_hdr_mode", o_hdr_mode, 1'b0);
      i_tgt_en = 1'b1; applyStimulus();

      // Frame counter saturation, SCL kept alive to avoid timeout
      enterHdr();
      for (int k = 0; k < 300; k++) begin
         if (k % 4 == 0) i_scl = ~i_scl;
         i_ddr_done = 1'b1;
         applyStimulus();
      end
      checkCount("frame_sat", o_frame_cnt, 8'hFF);

      // Reset mid-HDR aborts at once
      i_sys_rst = 1'b1; applyStimulus();
      checkOutput("midrst_hdr_mode", o_hdr_mode, 1'b0);
      checkOutput("midrst_ddr_en", o_ddr_en, 1'b0);
      checkCount("midrst_frames", o_frame_cnt, 8'd0);
      i_sys_rst = 1'b0;

      // Random bus activity against the model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 3) == 0) i_scl = ~i_scl;
         i_sda = 1'($urandom_range(0, 1));
         i_ddr_done = ($urandom_range(0, 5) == 0);
         i_enthdr_done = ($urandom_range(0, 7) == 0);
         i_tgt_en = ($urandom_range(0, 99) != 0);
         i_enthdr_sda = 1'($urandom_range(0, 1));
         i_enthdr_pp_od = 1'($urandom_range(0, 1));
         i_enthdr_sda_en = 1'($urandom_range(0, 1));
         i_ddr_sda = 1'($urandom_range(0, 1));
         i_ddr_pp_od = 1'($urandom_range(0, 1));
         i_ddr_sda_en = 1'($urandom_range(0, 1));
         i_sys_rst = ($urandom_range(0, 299) == 0);
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
